// File: rtl/accel_pkg.sv
// Shared constants for the FM-index inexact-recursion accelerator:
// InexRecur byte-field offsets, default entry widths and queue mode encoding.
package accel_pkg;

    // Default widths of the paired queue entry
    localparam int IR_W_DEF = 32;
    localparam int ST_W_DEF = 18;

    // Byte-field offsets inside an InexRecur word {i, z, k, l}
    localparam int IR_L_OFS = 0;
    localparam int IR_K_OFS = 8;
    localparam int IR_Z_OFS = 16;
    localparam int IR_I_OFS = 24;
    localparam int IR_FIELD_W = 8;

    // Service order of the work list
    typedef enum logic {
        MODE_FIFO = 1'b0,
        MODE_LIFO = 1'b1
    } mode_e;

endpackage

// File: rtl/inexrecur_entry_mem.sv
// Dual-array entry store: one push write (both arrays), one state-only
// update write, and two registered read ports that hold until next enable.
// The push write takes priority over a state update to the same index.
module inexrecur_entry_mem #(
    parameter int IR_W   = 32,
    parameter int ST_W   = 18,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [IR_W-1:0]   wr_ir,
    input  logic [ST_W-1:0]   wr_st,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [ST_W-1:0]   upd_st,
    input  logic              rd_a_en,
    input  logic [ADDR_W-1:0] rd_a_addr,
    output logic [IR_W-1:0]   rd_a_ir,
    output logic [ST_W-1:0]   rd_a_st,
    input  logic              rd_b_en,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [IR_W-1:0]   rd_b_ir,
    output logic [ST_W-1:0]   rd_b_st
);

    logic [IR_W-1:0] ir_mem [DEPTH];
    logic [ST_W-1:0] st_mem [DEPTH];
    logic            upd_hit;

    // A state update colliding with a push to the same slot is dropped
    always_comb begin
        upd_hit = upd_en && !(wr_en && (wr_addr == upd_addr));
    end

    // Array writes; no reset so the store maps onto plain storage
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ir_mem[wr_addr] <= wr_ir;
            st_mem[wr_addr] <= wr_st;
        end
        if (upd_hit) begin
            st_mem[upd_addr] <= upd_st;
        end
    end

    // Read port A (pop path): registered, read-before-write, holds when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_ir <= '0;
            rd_a_st <= '0;
        end else if (rd_a_en) begin
            rd_a_ir <= ir_mem[rd_a_addr];
            rd_a_st <= st_mem[rd_a_addr];
        end
    end

    // Read port B (random access): registered, read-before-write, holds when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_b_ir <= '0;
            rd_b_st <= '0;
        end else if (rd_b_en) begin
            rd_b_ir <= ir_mem[rd_b_addr];
            rd_b_st <= st_mem[rd_b_addr];
        end
    end

endmodule

// File: rtl/inexrecur_task_queue.sv
// Circular work-list of {InexRecur, state} entries served FIFO or LIFO,
// with a random read / state-update port for the accelerator FSM.
// Optional feature macro: TASK_QUEUE_HWM_EN adds the hwm_o occupancy peak.
module inexrecur_task_queue
    import accel_pkg::*;
#(
    parameter int IR_W   = IR_W_DEF,
    parameter int ST_W   = ST_W_DEF,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [IR_W-1:0]   push_ir_i,
    input  logic [ST_W-1:0]   push_st_i,
    output logic              push_ready_o,
    input  logic              pop_i,
    output logic              pop_valid_o,
    output logic [IR_W-1:0]   pop_ir_o,
    output logic [ST_W-1:0]   pop_st_o,
    output logic [ADDR_W-1:0] pop_addr_o,
    input  logic              ran_re_i,
    input  logic [ADDR_W-1:0] ran_r_addr_i,
    output logic              ran_valid_o,
    output logic [IR_W-1:0]   ran_ir_o,
    output logic [ST_W-1:0]   ran_st_o,
    input  logic              ran_we_i,
    input  logic [ADDR_W-1:0] ran_w_addr_i,
    input  logic [ST_W-1:0]   ran_w_st_i,
`ifdef TASK_QUEUE_HWM_EN
    output logic [ADDR_W:0]   hwm_o,
`endif
    output logic [ADDR_W:0]   count_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              mode_o
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] head_q, tail_q, tail_m1;
    logic [ADDR_W:0]   count_q, count_d;
    mode_e             mode_q;

    logic              push_acc, pop_acc, bypass;
    logic              mem_wr_en, mem_upd_en, mem_rd_en;
    logic [ADDR_W-1:0] pop_src;

    logic              byp_sel_q;
    logic [IR_W-1:0]   byp_ir_q;
    logic [ST_W-1:0]   byp_st_q;
    logic [IR_W-1:0]   mem_pop_ir;
    logic [ST_W-1:0]   mem_pop_st;

    // Request qualification, LIFO bypass detection and next occupancy
    always_comb begin
        tail_m1    = tail_q - PTR_ONE;
        push_acc   = push_i && !full_o && !flush_i;
        pop_acc    = pop_i && !empty_o && !flush_i;
        bypass     = push_acc && pop_acc && (mode_q == MODE_LIFO);
        mem_wr_en  = push_acc && !bypass;
        mem_rd_en  = pop_acc && !bypass;
        mem_upd_en = ran_we_i && !flush_i;
        pop_src    = (mode_q == MODE_LIFO) ? tail_m1 : head_q;
        count_d    = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (!bypass) begin
            if (push_acc && !pop_acc) count_d = count_q + CNT_ONE;
            if (pop_acc && !push_acc) count_d = count_q - CNT_ONE;
        end
    end

    // Status flags derive from the registered occupancy
    always_comb begin
        empty_o      = (count_q == '0);
        full_o       = (count_q == CNT_FULL);
        push_ready_o = !full_o;
        count_o      = count_q;
        mode_o       = mode_q;
    end

    // Pointer, occupancy and mode registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            mode_q  <= MODE_FIFO;
        end else begin
            count_q <= count_d;
            if (empty_o && !push_acc) mode_q <= mode_e'(mode_i);
            if (flush_i) begin
                head_q <= '0;
                tail_q <= '0;
            end else if (!bypass) begin
                // Only one of the tail updates can fire: a LIFO push+pop is a bypass
                if (pop_acc && mode_q == MODE_FIFO) head_q <= head_q + PTR_ONE;
                if (pop_acc && mode_q == MODE_LIFO) tail_q <= tail_m1;
                if (push_acc) tail_q <= tail_q + PTR_ONE;
            end
        end
    end

    // Pop handshake, source address and LIFO bypass capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_valid_o <= 1'b0;
            pop_addr_o  <= '0;
            byp_sel_q   <= 1'b0;
            byp_ir_q    <= '0;
            byp_st_q    <= '0;
        end else begin
            pop_valid_o <= pop_acc;
            if (pop_acc) begin
                pop_addr_o <= pop_src;
                byp_sel_q  <= bypass;
                if (bypass) begin
                    byp_ir_q <= push_ir_i;
                    byp_st_q <= push_st_i;
                end
            end
        end
    end

    // Random read completes regardless of flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ran_valid_o <= 1'b0;
        else        ran_valid_o <= ran_re_i;
    end

    // Pop data comes from the bypass capture or the store's pop read port
    always_comb begin
        pop_ir_o = byp_sel_q ? byp_ir_q : mem_pop_ir;
        pop_st_o = byp_sel_q ? byp_st_q : mem_pop_st;
    end

`ifdef TASK_QUEUE_HWM_EN
    logic [ADDR_W:0] hwm_q;

    // Peak occupancy since reset; tracked on the next count so it aligns with count_o
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 hwm_q <= '0;
        else if (count_d > hwm_q)   hwm_q <= count_d;
    end

    always_comb hwm_o = hwm_q;
`endif

    inexrecur_entry_mem #(
        .IR_W   (IR_W),
        .ST_W   (ST_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (mem_wr_en),
        .wr_addr   (tail_q),
        .wr_ir     (push_ir_i),
        .wr_st     (push_st_i),
        .upd_en    (mem_upd_en),
        .upd_addr  (ran_w_addr_i),
        .upd_st    (ran_w_st_i),
        .rd_a_en   (mem_rd_en),
        .rd_a_addr (pop_src),
        .rd_a_ir   (mem_pop_ir),
        .rd_a_st   (mem_pop_st),
        .rd_b_en   (ran_re_i),
        .rd_b_addr (ran_r_addr_i),
        .rd_b_ir   (ran_ir_o),
        .rd_b_st   (ran_st_o)
    );

endmodule

// File: tb/tb_inexrecur_task_queue.sv
// Directed bench for inexrecur_task_queue at DEPTH = 4.
// Covers FIFO/LIFO order, LIFO bypass, wrapped full queue, random
// read-before-write, flush and mode latching; hwm_o when TASK_QUEUE_HWM_EN.
module tb_inexrecur_task_queue;

    localparam int IR_W   = 32;
    localparam int ST_W   = 18;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mode_i, flush_i, push_i, pop_i;
    logic [IR_W-1:0]   push_ir_i;
    logic [ST_W-1:0]   push_st_i;
    logic              push_ready_o, pop_valid_o;
    logic [IR_W-1:0]   pop_ir_o;
    logic [ST_W-1:0]   pop_st_o;
    logic [ADDR_W-1:0] pop_addr_o;
    logic              ran_re_i, ran_valid_o, ran_we_i;
    logic [ADDR_W-1:0] ran_r_addr_i, ran_w_addr_i;
    logic [IR_W-1:0]   ran_ir_o;
    logic [ST_W-1:0]   ran_st_o, ran_w_st_i;
    logic [ADDR_W:0]   count_o;
    logic              empty_o, full_o, mode_o;
`ifdef TASK_QUEUE_HWM_EN
    logic [ADDR_W:0]   hwm_o;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [IR_W-1:0] ir_tab [4];
    logic [ST_W-1:0] st_tab [4];
    logic [IR_W-1:0] wr_tab [4];

    always #5 clk = ~clk;

    inexrecur_task_queue #(
        .IR_W   (IR_W),
        .ST_W   (ST_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode_i       (mode_i),
        .flush_i      (flush_i),
        .push_i       (push_i),
        .push_ir_i    (push_ir_i),
        .push_st_i    (push_st_i),
        .push_ready_o (push_ready_o),
        .pop_i        (pop_i),
        .pop_valid_o  (pop_valid_o),
        .pop_ir_o     (pop_ir_o),
        .pop_st_o     (pop_st_o),
        .pop_addr_o   (pop_addr_o),
        .ran_re_i     (ran_re_i),
        .ran_r_addr_i (ran_r_addr_i),
        .ran_valid_o  (ran_valid_o),
        .ran_ir_o     (ran_ir_o),
        .ran_st_o     (ran_st_o),
        .ran_we_i     (ran_we_i),
        .ran_w_addr_i (ran_w_addr_i),
        .ran_w_st_i   (ran_w_st_i),
`ifdef TASK_QUEUE_HWM_EN
        .hwm_o        (hwm_o),
`endif
        .count_o      (count_o),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .mode_o       (mode_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0;
        ran_re_i = 1'b0; ran_we_i = 1'b0;
    endtask

    task automatic push(input logic [IR_W-1:0] ir, input logic [ST_W-1:0] st);
        push_i = 1'b1; push_ir_i = ir; push_st_i = st;
        step();
        push_i = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [IR_W-1:0] ir,
                           input logic [ST_W-1:0] st, input logic [ADDR_W-1:0] a);
        pop_i = 1'b1;
        step();
        pop_i = 1'b0;
        check({tag, "_valid"}, 64'(pop_valid_o), 64'd1);
        check({tag, "_ir"},    64'(pop_ir_o),    64'(ir));
        check({tag, "_st"},    64'(pop_st_o),    64'(st));
        check({tag, "_addr"},  64'(pop_addr_o),  64'(a));
    endtask

    initial begin
        ir_tab[0] = 32'h02_01_00_06; st_tab[0] = 18'd0;
        ir_tab[1] = 32'h01_00_00_06; st_tab[1] = 18'd1;
        ir_tab[2] = 32'h00_ff_00_06; st_tab[2] = 18'd3;
        ir_tab[3] = 32'h00_f1_00_06; st_tab[3] = 18'd5;
        wr_tab[0] = 32'hD0; wr_tab[1] = 32'hD1; wr_tab[2] = 32'hD2; wr_tab[3] = 32'hD3;

        rst_n = 1'b0; mode_i = 1'b0;
        push_ir_i = '0; push_st_i = '0;
        ran_r_addr_i = '0; ran_w_addr_i = '0; ran_w_st_i = '0;
        idle();
        step(); step();
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_empty", 64'(empty_o), 64'd1);
        check("rst_full",  64'(full_o), 64'd0);
        check("rst_ready", 64'(push_ready_o), 64'd1);
        check("rst_mode",  64'(mode_o), 64'd0);
        check("rst_pv",    64'(pop_valid_o), 64'd0);
        check("rst_pir",   64'(pop_ir_o), 64'd0);
        check("rst_paddr", 64'(pop_addr_o), 64'd0);
        check("rst_rv",    64'(ran_valid_o), 64'd0);
        check("rst_rst",   64'(ran_st_o), 64'd0);

`ifdef TASK_QUEUE_HWM_EN
        // Peak tracking: push 3, pop 2, push 1 -> peak 3, survives flush
        push(32'h11, 18'd1); push(32'h12, 18'd2); push(32'h13, 18'd3);
        pop_i = 1'b1; step(); step(); pop_i = 1'b0;
        push(32'h14, 18'd4);
        check("hwm_cnt", 64'(count_o), 64'd2);
        check("hwm_val", 64'(hwm_o), 64'd3);
        flush_i = 1'b1; step(); flush_i = 1'b0;
        check("hwm_flush", 64'(hwm_o), 64'd3);
        check("hwm_fcnt", 64'(count_o), 64'd0);
`endif

        // FIFO order from a clean queue
        for (int i = 0; i < 4; i++) push(ir_tab[i], st_tab[i]);
        check("fifo_full", 64'(full_o), 64'd1);
        for (int i = 0; i < 4; i++)
            pop_chk($sformatf("fifo_pop%0d", i), ir_tab[i], st_tab[i], ADDR_W'(i));
        check("fifo_empty", 64'(empty_o), 64'd1);
        step();
        check("fifo_pv_drop", 64'(pop_valid_o), 64'd0);
        check("fifo_hold", 64'(pop_ir_o), 64'(ir_tab[3]));

        // Switch to LIFO while empty
        mode_i = 1'b1; step();
        check("lifo_mode", 64'(mode_o), 64'd1);
        for (int i = 0; i < 4; i++) push(ir_tab[i], st_tab[i]);
        pop_chk("lifo_pop0", ir_tab[3], st_tab[3], 2'd3);
        check("lifo_cnt3", 64'(count_o), 64'd3);
        // Same-cycle push+pop bypasses the store
        push_i = 1'b1; push_ir_i = 32'hAA; push_st_i = 18'h2A; pop_i = 1'b1;
        step();
        idle();
        check("byp_ir",   64'(pop_ir_o), 64'hAA);
        check("byp_st",   64'(pop_st_o), 64'h2A);
        check("byp_addr", 64'(pop_addr_o), 64'd2);
        check("byp_cnt",  64'(count_o), 64'd3);
        for (int i = 2; i >= 0; i--)
            pop_chk($sformatf("lifo_pop_a%0d", i), ir_tab[i], st_tab[i], ADDR_W'(i));
        check("lifo_empty", 64'(empty_o), 64'd1);

        // Back to FIFO; advance head/tail to 2 so the fill wraps
        mode_i = 1'b0; step();
        check("fifo_mode", 64'(mode_o), 64'd0);
        push(32'h55, 18'd0); push(32'h66, 18'd0);
        pop_i = 1'b1; step(); step(); pop_i = 1'b0;
        for (int i = 0; i < 4; i++) push(wr_tab[i], ST_W'(i + 8));
        check("wrap_full",  64'(full_o), 64'd1);
        check("wrap_ready", 64'(push_ready_o), 64'd0);
        check("wrap_cnt",   64'(count_o), 64'd4);
        push(32'hEE, 18'h1);
        check("wrap_drop_cnt", 64'(count_o), 64'd4);
        for (int i = 0; i < 4; i++)
            pop_chk($sformatf("wrap_pop%0d", i), wr_tab[i], ST_W'(i + 8), ADDR_W'((i + 2) % 4));
        check("wrap_empty", 64'(empty_o), 64'd1);

        // Random update and read to index 1 (holds D3, state 11)
        ran_we_i = 1'b1; ran_w_addr_i = 2'd1; ran_w_st_i = 18'h3FFFF;
        ran_re_i = 1'b1; ran_r_addr_i = 2'd1;
        step();
        ran_we_i = 1'b0;
        check("ran_v0",   64'(ran_valid_o), 64'd1);
        check("ran_old",  64'(ran_st_o), 64'd11);
        check("ran_ir0",  64'(ran_ir_o), 64'hD3);
        step();
        ran_re_i = 1'b0;
        check("ran_new",  64'(ran_st_o), 64'h3FFFF);
        check("ran_ir1",  64'(ran_ir_o), 64'hD3);
        step();
        check("ran_v_off", 64'(ran_valid_o), 64'd0);
        check("ran_hold",  64'(ran_st_o), 64'h3FFFF);

        // Flush with three entries plus a push; mode latches once empty
        push(32'h71, 18'd1); push(32'h72, 18'd2); push(32'h73, 18'd3);
        check("fl_cnt3", 64'(count_o), 64'd3);
        flush_i = 1'b1; push_i = 1'b1; push_ir_i = 32'h74; mode_i = 1'b1;
        step();
        idle();
        check("fl_cnt0",  64'(count_o), 64'd0);
        check("fl_empty", 64'(empty_o), 64'd1);
        check("fl_mode_hold", 64'(mode_o), 64'd0);
        step();
        check("fl_mode", 64'(mode_o), 64'd1);
        mode_i = 1'b0;
        // Pop on empty alongside a push is ignored; the push lands
        push_i = 1'b1; push_ir_i = 32'h81; push_st_i = 18'd7; pop_i = 1'b1;
        step();
        idle();
        check("emp_pop_pv",  64'(pop_valid_o), 64'd0);
        check("emp_pop_cnt", 64'(count_o), 64'd1);
`ifdef TASK_QUEUE_HWM_EN
        check("hwm_end", 64'(hwm_o), 64'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time bound so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
